// File: rtl/imem_loader.sv
// Boot-image loader: takes a length-prefixed little-endian byte stream, writes
// 32-bit words into instruction memory, and holds the core in reset until done.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          start,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst_n,
  output logic          load_done,
  output logic          err
);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   asm_q, asm_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          load_done_q, load_done_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          err_q, err_d;

  logic          accept;
  logic [15:0]   hdr_count;
  logic [31:0]   word_asm;

  assign in_ready  = (state_q != DONE);
  assign accept    = in_valid & in_ready;
  assign hdr_count = {in_data, count_q[7:0]};

  // Assembly register with the incoming byte already merged into its lane,
  // so the 4th byte can be written out on the same edge it is accepted.
  always_comb begin
    word_asm = asm_q;
    word_asm[{byte_idx_q, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = load_done_q;
    cpu_rst_n_d = cpu_rst_n_q;
    err_d       = err_q;
    case (state_q)
      HDR0: if (accept) begin
        count_d[7:0] = in_data;
        state_d      = HDR1;
      end
      HDR1: if (accept) begin
        count_d[15:8] = in_data;
        if (hdr_count == 16'd0) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
          if (hdr_count > 16'(DEPTH)) err_d = 1'b1;
        end
      end
      DATA: if (accept) begin
        asm_d      = word_asm;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          // Oversized images are drained but never wrap onto low addresses.
          if (word_idx_q < 16'(DEPTH)) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = word_idx_q[AW-1:0];
            mem_wdata_d = word_asm;
          end
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_q + 16'd1 == count_q) state_d = DONE;
        end
      end
      DONE: begin
        // Registered one edge late so release trails the last write pulse.
        load_done_d = 1'b1;
        cpu_rst_n_d = 1'b1;
        if (start) begin
          state_d     = HDR0;
          load_done_d = 1'b0;
          cpu_rst_n_d = 1'b0;
          err_d       = 1'b0;
          word_idx_d  = 16'd0;
          byte_idx_d  = 2'd0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign load_done = load_done_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives boot images byte by byte and checks
// the memory write pulses and core-release timing against hand-computed values.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        load_done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         wq[$];
  logic [31:0] img[$];

  imem_loader #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{a: mem_waddr, d: mem_wdata});

  // Called at a negedge; presents one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) @(negedge clk);
  endtask

  // Header n, then nw words from img; returns at the negedge right after the last accepted byte.
  task automatic load_image(input int n, input int nw, input int gap);
    logic [15:0] h;
    logic [31:0] w;
    h = 16'(n);
    send(h[7:0], gap);
    send(h[15:8], (nw == 0) ? 0 : gap);
    for (int i = 0; i < nw; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++)
        send(w[8*k +: 8], (i == nw - 1 && k == 3) ? 0 : gap);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_word_load(input string nm);
    n_tests++;
    if (mem_we !== 1'b1 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s last_pulse: mem_we=%b load_done=%b, want 1/0", nm, mem_we, load_done);
    end
    @(negedge clk);
    n_tests++;
    if (load_done !== 1'b1 || cpu_rst_n !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: load_done=%b cpu_rst_n=%b in_ready=%b mem_we=%b, want 1/1/0/0",
               nm, load_done, cpu_rst_n, in_ready, mem_we);
    end
    n_tests++;
    if (wq.size() != 2) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d want 2", nm, wq.size());
    end else if (wq[0].a !== 6'd0 || wq[0].d !== 32'h00A00513 ||
                 wq[1].a !== 6'd1 || wq[1].d !== 32'h00100593) begin
      n_fail++;
      $display("FAIL %s writes: got %0d:%h %0d:%h want 0:00a00513 1:00100593",
               nm, wq[0].a, wq[0].d, wq[1].a, wq[1].d);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (mem_we !== 1'b0 || mem_waddr !== 6'd0 || mem_wdata !== 32'd0 || load_done !== 1'b0 ||
        cpu_rst_n !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: we=%b addr=%0d data=%h done=%b crst=%b err=%b rdy=%b", mem_we,
               mem_waddr, mem_wdata, load_done, cpu_rst_n, err, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wq.delete();
    img = '{32'h00A00513, 32'h00100593};
    load_image(2, 2, 0);
    check_two_word_load("basic");
  endtask

  task automatic test_start_restart();
    wq.delete();
    pulse_start();
    n_tests++;
    if (load_done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_restart: done=%b crst=%b rdy=%b err=%b want 0/0/1/0",
               load_done, cpu_rst_n, in_ready, err);
    end
    @(negedge clk);
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL start_no_we: got %0d writes want 0", wq.size());
    end
  endtask

  task automatic test_stall();
    wq.delete();
    img = '{32'h00A00513, 32'h00100593};
    load_image(2, 2, 3);
    check_two_word_load("stall");
  endtask

  task automatic test_zero_count();
    wq.delete();
    load_image(0, 0, 0);
    n_tests++;
    if (load_done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_enter: done=%b rdy=%b want 0/0", load_done, in_ready);
    end
    @(negedge clk);
    n_tests++;
    if (load_done !== 1'b1 || cpu_rst_n !== 1'b1 || err !== 1'b0 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b crst=%b err=%b writes=%0d want 1/1/0/0",
               load_done, cpu_rst_n, err, wq.size());
    end
  endtask

  task automatic test_overflow();
    int bad;
    wq.delete();
    img.delete();
    for (int i = 0; i < 66; i++)
      img.push_back({8'(i), 8'hA5, 8'(i) ^ 8'h3C, 8'(i + 1)});
    load_image(66, 66, 0);
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || load_done !== 1'b1 || cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flags: err=%b done=%b crst=%b want 1/1/1", err, load_done, cpu_rst_n);
    end
    n_tests++;
    if (wq.size() != 64) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes want 64", wq.size());
    end
    bad = 0;
    for (int i = 0; i < wq.size() && i < 64; i++)
      if (wq[i].a !== 6'(i) || wq[i].d !== {8'(i), 8'hA5, 8'(i) ^ 8'h3C, 8'(i + 1)}) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL overflow_data: %0d bad writes, want 0", bad);
    end
    wq.delete();
    pulse_start();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_midload();
    wq.delete();
    img = '{32'h00A00513, 32'h00100593};
    send(8'h02, 0);
    send(8'h00, 0);
    for (int k = 0; k < 6; k++) send((k < 4) ? img[0][8*k +: 8] : img[1][8*(k-4) +: 8], 0);
    n_tests++;
    if (wq.size() != 1 || mem_wdata !== 32'h00A00513) begin
      n_fail++;
      $display("FAIL midload_pre: writes=%0d data=%h want 1/00a00513", wq.size(), mem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_wdata !== 32'd0 || mem_waddr !== 6'd0 || load_done !== 1'b0 || cpu_rst_n !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: data=%h addr=%0d done=%b crst=%b err=%b rdy=%b we=%b",
               mem_wdata, mem_waddr, load_done, cpu_rst_n, err, in_ready, mem_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wq.delete();
    img = '{32'hDEADBEEF};
    load_image(1, 1, 0);
    @(negedge clk);
    n_tests++;
    if (wq.size() != 1 || load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_count: writes=%0d done=%b want 1/1", wq.size(), load_done);
    end else if (wq[0].a !== 6'd0 || wq[0].d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fresh_write: got %0d:%h want 0:deadbeef", wq[0].a, wq[0].d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_restart();
    test_stall();
    pulse_start();
    test_zero_count();
    pulse_start();
    test_overflow();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
